// File: rtl/ct_noise_adder.sv
`default_nettype none
// ============================================================================
// ct_noise_adder: buffers the multiplier product stream and forms
// c = z + sext(e) + (m ? DELTA : 0) mod 2^QW, one coefficient per fire.
// Revision: 1.0
// ============================================================================
module ct_noise_adder #(
    parameter int N     = 16,
    parameter int QW    = 8,
    parameter int EW    = 4,
    parameter int DELTA = 2**(QW-1)
) (
    input  logic          clk,
    input  logic          a_rst_n,
    input  logic          z_tvalid,
    input  logic [QW-1:0] z_tdata,
    input  logic          z_tlast,
    input  logic          e_tvalid,
    output logic          e_tready,
    input  logic [EW:0]   e_tdata,
    input  logic          e_tlast,
    output logic          c_tvalid,
    input  logic          c_tready,
    output logic [QW-1:0] c_tdata,
    output logic          c_tlast,
    output logic          err_overflow,
    output logic          err_frame
);
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N + 1);
    localparam logic [AW-1:0] C_LAST_IDX = AW'(N - 1);
    localparam logic [CW-1:0] C_FULL     = CW'(N);
    localparam logic [QW-1:0] C_DELTA    = QW'(DELTA);

    logic [1:0]    r_rst_sync;
    logic          w_rst_n;
    logic [QW-1:0] r_mem [N];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_wr_idx;
    logic [AW-1:0] r_pop_idx;

    logic          w_not_empty;
    logic          w_full;
    logic          w_out_free;
    logic          w_fire;
    logic          w_push;
    logic          w_drop;
    logic          w_wr_at_last;
    logic          w_pop_at_last;
    logic [QW-1:0] w_err_ext;
    logic [QW-1:0] w_msg;
    logic [QW-1:0] w_sum;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == C_LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_not_empty   = (r_count != '0);
    assign w_full        = (r_count == C_FULL);
    assign w_out_free    = !c_tvalid || c_tready;
    assign w_fire        = w_not_empty && e_tvalid && w_out_free;
    assign e_tready      = w_not_empty && w_out_free;
    // A full buffer still accepts a beat when the head leaves in the same cycle.
    assign w_push        = z_tvalid && (!w_full || w_fire);
    assign w_drop        = z_tvalid && w_full && !w_fire;
    assign w_wr_at_last  = (r_wr_idx == C_LAST_IDX);
    assign w_pop_at_last = (r_pop_idx == C_LAST_IDX);

    assign w_err_ext = {{(QW-EW){e_tdata[EW-1]}}, e_tdata[EW-1:0]};
    assign w_msg     = e_tdata[EW] ? C_DELTA : '0;
    assign w_sum     = r_mem[r_rd_ptr] + w_err_ext + w_msg;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= z_tdata;
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_wr_idx  <= '0;
            r_pop_idx <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= wrap_inc(r_wr_ptr);
                r_wr_idx <= wrap_inc(r_wr_idx);
            end
            if (w_fire) begin
                r_rd_ptr  <= wrap_inc(r_rd_ptr);
                r_pop_idx <= wrap_inc(r_pop_idx);
            end
            if (w_push && !w_fire) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_fire) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            c_tvalid <= 1'b0;
            c_tdata  <= '0;
            c_tlast  <= 1'b0;
        end else if (w_fire) begin
            c_tvalid <= 1'b1;
            c_tdata  <= w_sum;
            c_tlast  <= w_pop_at_last;
        end else if (c_tready) begin
            c_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            err_overflow <= 1'b0;
            err_frame    <= 1'b0;
        end else begin
            if (w_drop) begin
                err_overflow <= 1'b1;
            end
            if ((w_push && (z_tlast != w_wr_at_last)) ||
                (w_fire && (e_tlast != w_pop_at_last))) begin
                err_frame <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ct_noise_adder.sv
`default_nettype none
// ============================================================================
// tb_ct_noise_adder: directed stimulus checked against a queue-based model.
// Revision: 1.0
// ============================================================================
module tb_ct_noise_adder;
    localparam int N  = 16;
    localparam int QW = 8;
    localparam int EW = 4;

    logic          clk      = 1'b0;
    logic          a_rst_n  = 1'b0;
    logic          z_tvalid = 1'b0;
    logic [QW-1:0] z_tdata  = '0;
    logic          z_tlast  = 1'b0;
    logic          e_tvalid = 1'b0;
    logic          e_tready;
    logic [EW:0]   e_tdata  = '0;
    logic          e_tlast  = 1'b0;
    logic          c_tvalid;
    logic          c_tready = 1'b1;
    logic [QW-1:0] c_tdata;
    logic          c_tlast;
    logic          err_overflow;
    logic          err_frame;

    ct_noise_adder #(.N(N), .QW(QW), .EW(EW), .DELTA(2**(QW-1))) dut (
        .clk(clk), .a_rst_n(a_rst_n),
        .z_tvalid(z_tvalid), .z_tdata(z_tdata), .z_tlast(z_tlast),
        .e_tvalid(e_tvalid), .e_tready(e_tready), .e_tdata(e_tdata), .e_tlast(e_tlast),
        .c_tvalid(c_tvalid), .c_tready(c_tready), .c_tdata(c_tdata), .c_tlast(c_tlast),
        .err_overflow(err_overflow), .err_frame(err_frame)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int beats    = 0;
    int n_last   = 0;
    int last_pos = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of pending products and the visible output word.
    int zq[$];
    bit m_valid, m_last, m_ovf, m_ferr;
    int m_data, m_zidx, m_eidx;

    function automatic int noise(input logic [EW:0] e);
        int v;
        v = $signed(e[EW-1:0]);
        return v + (e[EW] ? (1 << (QW-1)) : 0);
    endfunction

    task automatic model_clear();
        zq.delete();
        m_valid = 0; m_last = 0; m_ovf = 0; m_ferr = 0;
        m_data = 0; m_zidx = 0; m_eidx = 0;
    endtask

    task automatic model_step();
        bit fire;
        int z;
        fire = (zq.size() != 0) && e_tvalid && (!m_valid || c_tready);
        if (fire) begin
            z = zq.pop_front();
            m_data = (((z + noise(e_tdata)) % 256) + 256) % 256;
            if (e_tlast != (m_eidx == N-1)) m_ferr = 1;
            m_last  = (m_eidx == N-1);
            m_eidx  = (m_eidx + 1) % N;
            m_valid = 1;
        end else if (c_tready) begin
            m_valid = 0;
        end
        if (z_tvalid) begin
            if (zq.size() == N && !fire) begin
                m_ovf = 1;
            end else begin
                zq.push_back(int'(z_tdata));
                if (z_tlast != (m_zidx == N-1)) m_ferr = 1;
                m_zidx = (m_zidx + 1) % N;
            end
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge a_rst_n);
            if (!a_rst_n) model_clear();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("c_tvalid", c_tvalid, m_valid);
            if (m_valid) begin
                check("c_tdata", c_tdata, m_data);
                check("c_tlast", c_tlast, m_last);
            end
            check("e_tready", e_tready, (zq.size() != 0) && (!m_valid || c_tready));
            check("err_overflow", err_overflow, m_ovf);
            check("err_frame", err_frame, m_ferr);
            if (c_tvalid && c_tready) begin
                beats++;
                if (c_tlast) begin
                    n_last++;
                    last_pos = beats;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        z_tvalid = 0; z_tdata = '0; z_tlast = 0;
        e_tvalid = 0; e_tdata = '0; e_tlast = 0;
        c_tready = 1;
    endtask

    // Release waits past the two-edge reset synchroniser before stimulus resumes.
    task automatic do_reset();
        clear_inputs();
        a_rst_n = 0;
        tick(); tick();
        a_rst_n = 1;
        repeat (3) tick();
        beats = 0; n_last = 0; last_pos = 0;
    endtask

    task automatic send_pair(input string name, input int z, input logic [EW:0] e, input int exp);
        z_tvalid = 1; z_tdata = QW'(z); e_tvalid = 1; e_tdata = e;
        tick();
        z_tvalid = 0;
        check({name, "_lat1"}, c_tvalid, 0);
        tick();
        check({name, "_valid"}, c_tvalid, 1);
        check(name, c_tdata, exp);
        e_tvalid = 0;
    endtask

    task automatic run_frame(input int ztlast_pos, input int stop_after);
        int zi, ei, cyc;
        bit hs;
        zi = 0; ei = 0; cyc = 0;
        while (ei < N && beats < stop_after && cyc < 200) begin
            z_tvalid = (zi < N);
            z_tdata  = QW'(zi * 17 + 3);
            z_tlast  = (zi == ztlast_pos);
            e_tvalid = 1;
            e_tdata  = (EW+1)'(ei * 7 + 2);
            e_tlast  = (ei == N-1);
            hs = e_tready;
            tick();
            if (zi < N) zi++;
            if (hs) ei++;
            cyc++;
        end
        z_tvalid = 0; z_tlast = 0; e_tvalid = 0; e_tlast = 0;
        if (cyc >= 200) check("frame_timeout", cyc, 0);
    endtask

    initial begin
        clear_inputs();
        a_rst_n = 0;
        tick();
        check("rst_c_tvalid", c_tvalid, 0);
        check("rst_c_tdata", c_tdata, 0);
        check("rst_c_tlast", c_tlast, 0);
        check("rst_e_tready", e_tready, 0);
        check("rst_err_overflow", err_overflow, 0);
        check("rst_err_frame", err_frame, 0);

        // Basic arithmetic, including carry wrap and negative errors.
        do_reset();
        send_pair("t1_z10", 10, 5'h03, 13);
        send_pair("t1_z250", 250, 5'h17, 129);
        send_pair("t2_z2", 2, 5'h0C, 254);
        send_pair("t2_z0", 0, 5'h18, 120);
        tick();

        // Fill the buffer, overflow it, then drain it.
        do_reset();
        for (int i = 0; i < N; i++) begin
            z_tvalid = 1; z_tdata = QW'(i * 13 + 1); z_tlast = (i == N-1);
            tick();
        end
        z_tlast = 0;
        check("t3_no_ovf", err_overflow, 0);
        z_tdata = 8'd99;
        tick();
        z_tvalid = 0;
        check("t3_ovf", err_overflow, 1);
        for (int i = 0; i < N; i++) begin
            e_tvalid = 1; e_tdata = (EW+1)'(i * 11); e_tlast = (i == N-1);
            check("t3_e_ready", e_tready, 1);
            tick();
        end
        e_tvalid = 0; e_tlast = 0;
        tick(); tick();
        check("t3_beats", beats, 16);
        check("t3_nlast", n_last, 1);
        check("t3_last_pos", last_pos, 16);
        check("t3_frame_ok", err_frame, 0);

        // Backpressure: output held, nothing lost.
        do_reset();
        c_tready = 0; e_tvalid = 1; e_tdata = 5'h01;
        for (int i = 0; i < 4; i++) begin
            z_tvalid = 1; z_tdata = QW'(20 + i);
            tick();
        end
        z_tvalid = 0;
        for (int k = 0; k < 5; k++) begin
            check("t4_hold_valid", c_tvalid, 1);
            check("t4_hold_data", c_tdata, 21);
            check("t4_hold_last", c_tlast, 0);
            check("t4_e_blocked", e_tready, 0);
            tick();
        end
        c_tready = 1;
        tick();
        check("t4_r1", c_tdata, 22);
        tick();
        check("t4_r2", c_tdata, 23);
        tick();
        check("t4_r3", c_tdata, 24);
        check("t4_r3_valid", c_tvalid, 1);
        tick();
        check("t4_drained", c_tvalid, 0);
        check("t4_beats", beats, 4);
        e_tvalid = 0;

        // Misplaced z_tlast flags an error but leaves data and c_tlast alone.
        do_reset();
        run_frame(5, N + 1);
        tick(); tick();
        check("t5_err_frame", err_frame, 1);
        check("t5_beats", beats, 16);
        check("t5_nlast", n_last, 1);
        check("t5_last_pos", last_pos, 16);

        // Asynchronous reset mid-frame, then a clean frame.
        do_reset();
        run_frame(N-1, 7);
        check("t6_seven_out", beats, 7);
        clear_inputs();
        #2;
        a_rst_n = 0;
        #1;
        check("t6_rst_c_tvalid", c_tvalid, 0);
        check("t6_rst_c_tdata", c_tdata, 0);
        check("t6_rst_c_tlast", c_tlast, 0);
        check("t6_rst_e_tready", e_tready, 0);
        tick();
        a_rst_n = 1;
        repeat (3) tick();
        beats = 0; n_last = 0; last_pos = 0;
        run_frame(N-1, N + 1);
        tick(); tick();
        check("t6_beats", beats, 16);
        check("t6_last_pos", last_pos, 16);
        check("t6_nlast", n_last, 1);
        check("t6_err_frame", err_frame, 0);
        check("t6_err_overflow", err_overflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
